// File: rtl/atm_account_arbiter_if.sv
// rtl/atm_account_arbiter_if.sv - terminal-side request/response bundle for the account arbiter
interface atm_account_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int AMT_W   = 32
);
    logic [NUM_REQ-1:0]       req;
    logic [2*NUM_REQ-1:0]     op;
    logic [AMT_W*NUM_REQ-1:0] amount;
    logic [NUM_REQ-1:0]       grant;
    logic                     done;
    logic [1:0]               status;
    logic [AMT_W-1:0]         balance_out;
    logic                     busy;

    modport master (
        output req, op, amount,
        input  grant, done, status, balance_out, busy
    );

    modport slave (
        input  req, op, amount,
        output grant, done, status, balance_out, busy
    );
endinterface

// File: rtl/atm_account_arbiter.sv
// rtl/atm_account_arbiter.sv - round-robin owner of the shared account balance
module atm_account_arbiter #(
    parameter int               NUM_REQ      = 2,
    parameter int               AMT_W        = 32,
    parameter logic [AMT_W-1:0] INIT_BALANCE = AMT_W'(32'h000186A0)
) (
    input  logic                   clk,
    input  logic                   reset,
    atm_account_arbiter_if.slave   bus
);
    localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

    localparam logic [1:0] OP_BAL = 2'b00;
    localparam logic [1:0] OP_WD  = 2'b01;
    localparam logic [1:0] OP_DEP = 2'b10;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_NSF   = 2'b01;
    localparam logic [1:0] ST_ILL   = 2'b10;
    localparam logic [1:0] ST_OVF   = 2'b11;

    typedef enum logic [1:0] {IDLE, EXEC, RESP, RELEASE} state_t;

    state_t             state;
    logic [AMT_W-1:0]   balance;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   win;
    logic [1:0]         lat_op;
    logic [AMT_W-1:0]   lat_amt;
    logic [NUM_REQ-1:0] grant_q;
    logic               done_q;
    logic [1:0]         status_q;
    logic [AMT_W-1:0]   balance_out_q;
    logic               busy_q;

    logic               found;
    logic [IDX_W-1:0]   next_idx;
    logic [AMT_W:0]     sum;
    logic [1:0]         exec_status;
    logic [AMT_W-1:0]   exec_balance;

    function automatic logic [IDX_W-1:0] rr_cand(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ)
            s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin
        found    = 1'b0;
        next_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req[rr_cand(rr_ptr, k)]) begin
                found    = 1'b1;
                next_idx = rr_cand(rr_ptr, k);
            end
        end
    end

    assign sum = {1'b0, balance} + {1'b0, lat_amt};

    always_comb begin
        exec_status  = ST_OK;
        exec_balance = balance;
        case (lat_op)
            OP_BAL: exec_status = ST_OK;
            OP_WD: begin
                if (lat_amt > balance)
                    exec_status = ST_NSF;
                else
                    exec_balance = balance - lat_amt;
            end
            OP_DEP: begin
                if (sum[AMT_W])
                    exec_status = ST_OVF;
                else
                    exec_balance = sum[AMT_W-1:0];
            end
            default: exec_status = ST_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            balance       <= INIT_BALANCE;
            rr_ptr        <= '0;
            win           <= '0;
            lat_op        <= OP_BAL;
            lat_amt       <= '0;
            grant_q       <= '0;
            done_q        <= 1'b0;
            status_q      <= ST_OK;
            balance_out_q <= INIT_BALANCE;
            busy_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        win     <= next_idx;
                        lat_op  <= bus.op[2*int'(next_idx) +: 2];
                        lat_amt <= bus.amount[AMT_W*int'(next_idx) +: AMT_W];
                        grant_q <= NUM_REQ'(1) << next_idx;
                        busy_q  <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    // Atomic commit; results are published together with done.
                    balance       <= exec_balance;
                    balance_out_q <= exec_balance;
                    status_q      <= exec_status;
                    done_q        <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    done_q <= 1'b0;
                    rr_ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
                    state  <= RELEASE;
                end
                default: begin
                    if (!bus.req[win]) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.done        = done_q;
    assign bus.status      = status_q;
    assign bus.balance_out = balance_out_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_atm_account_arbiter.sv
// tb/tb_atm_account_arbiter.sv - directed self-checking bench for atm_account_arbiter
module tb_atm_account_arbiter;
    localparam int NUM_REQ = 2;
    localparam int AMT_W   = 32;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    atm_account_arbiter_if #(.NUM_REQ(NUM_REQ), .AMT_W(AMT_W)) bus ();

    atm_account_arbiter #(
        .NUM_REQ(NUM_REQ),
        .AMT_W(AMT_W),
        .INIT_BALANCE(32'h000186A0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transaction from terminal t; req drops while done is high.
    task automatic do_txn(input int t, input logic [1:0] opc, input logic [31:0] amt,
                          input logic [1:0] exp_st, input logic [31:0] exp_bal,
                          input bit scramble);
        bus.req[t]             = 1'b1;
        bus.op[2*t +: 2]       = opc;
        bus.amount[32*t +: 32] = amt;
        tick();
        check($sformatf("grant_t%0d", t), 64'(bus.grant), 64'(2'b01 << t));
        check("busy_exec", 64'(bus.busy), 64'd1);
        check("done_exec", 64'(bus.done), 64'd0);
        if (scramble) begin
            bus.op[2*t +: 2]       = 2'b11;
            bus.amount[32*t +: 32] = 32'd999;
        end
        tick();
        check("done_resp", 64'(bus.done), 64'd1);
        check("status", 64'(bus.status), 64'(exp_st));
        check("balance_out", 64'(bus.balance_out), 64'(exp_bal));
        check("grant_resp", 64'(bus.grant), 64'(2'b01 << t));
        bus.req[t] = 1'b0;
        tick();
        check("done_pulse", 64'(bus.done), 64'd0);
        check("grant_release", 64'(bus.grant), 64'(2'b01 << t));
        check("status_hold", 64'(bus.status), 64'(exp_st));
        tick();
        check("grant_idle", 64'(bus.grant), 64'd0);
        check("busy_idle", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        bus.req    = '0;
        bus.op     = '0;
        bus.amount = '0;
        @(negedge clk);
        tick();
        reset = 1'b0;
        check("rst_grant", 64'(bus.grant), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_status", 64'(bus.status), 64'd0);
        check("rst_balance", 64'(bus.balance_out), 64'd100000);
        check("rst_busy", 64'(bus.busy), 64'd0);

        do_txn(0, 2'b00, 32'd0,          2'b00, 32'd100000, 1'b0);
        do_txn(1, 2'b01, 32'd30000,      2'b00, 32'd70000,  1'b0);
        do_txn(0, 2'b10, 32'd5000,       2'b00, 32'd75000,  1'b0);
        do_txn(1, 2'b01, 32'd75001,      2'b01, 32'd75000,  1'b0);
        do_txn(0, 2'b01, 32'd75000,      2'b00, 32'd0,      1'b0);
        do_txn(1, 2'b10, 32'd1,          2'b00, 32'd1,      1'b0);
        do_txn(0, 2'b10, 32'hFFFFFFFF,   2'b11, 32'd1,      1'b0);
        do_txn(1, 2'b11, 32'd50,         2'b10, 32'd1,      1'b0);
        do_txn(0, 2'b01, 32'd0,          2'b00, 32'd1,      1'b0);
        do_txn(1, 2'b10, 32'd100,        2'b00, 32'd101,    1'b1);

        // Fresh reset so rr_ptr starts at 0, then both terminals keep requesting.
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        bus.op     = '0;
        bus.amount = '0;
        bus.req    = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] exp_g;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            check($sformatf("alt_grant_%0d", i), 64'(bus.grant), 64'(exp_g));
            tick();
            check("alt_done", 64'(bus.done), 64'd1);
            check("alt_not_multi", 64'(bus.grant == 2'b11), 64'd0);
            bus.req = bus.req & ~exp_g;
            tick();
            check("alt_release_grant", 64'(bus.grant), 64'(exp_g));
            tick();
            check("alt_idle_grant", 64'(bus.grant), 64'd0);
            bus.req = 2'b11;
        end
        bus.req = 2'b00;
        tick();

        // Reset during EXEC of a withdraw must not commit.
        bus.req[0]         = 1'b1;
        bus.op[1:0]        = 2'b01;
        bus.amount[31:0]   = 32'd40000;
        tick();
        check("abort_grant_exec", 64'(bus.grant), 64'd1);
        reset   = 1'b1;
        bus.req = 2'b00;
        tick();
        check("abort_grant", 64'(bus.grant), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_balance", 64'(bus.balance_out), 64'd100000);
        reset = 1'b0;
        tick();
        check("abort_no_done", 64'(bus.done), 64'd0);
        do_txn(0, 2'b00, 32'd0, 2'b00, 32'd100000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
